// File: rtl/layer_sequencer_if.sv
// Bus between the layer sequencer and its environment: host handshake,
// input/weight memory read ports, perceptron bank controls and activations.
// The master modport is the sequencer side; slave is the surrounding logic.
interface layer_sequencer_if #(
  parameter int NUM_INPUTS   = 42,
  parameter int NUM_NEURONS  = 7,
  parameter int INPUT_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = INPUT_WIDTH + WEIGHT_WIDTH - 5,
  parameter int ADDR_WIDTH   = $clog2(NUM_INPUTS)
) ();

  // host handshake
  logic                                 start;
  logic                                 busy;
  logic                                 done;
  // synchronous memory read ports (1-cycle latency)
  logic [ADDR_WIDTH-1:0]                in_addr;
  logic [ADDR_WIDTH-1:0]                w_addr;
  logic [INPUT_WIDTH-1:0]               in_data;
  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0]  w_data;
  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0]  bias_in;
  // perceptron bank
  logic                                 neuron_rst;
  logic                                 neuron_en;
  logic [INPUT_WIDTH-1:0]               data_out;
  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0]  weight_out;
  logic [NUM_NEURONS*SUM_WIDTH-1:0]     sum_in;
  // layer result
  logic [NUM_NEURONS*INPUT_WIDTH-1:0]   act_out;

  modport master (
    input  start,
    output busy, done,
    output in_addr, w_addr,
    input  in_data, w_data, bias_in,
    output neuron_rst, neuron_en, data_out, weight_out,
    input  sum_in,
    output act_out
  );

  modport slave (
    output start,
    input  busy, done,
    input  in_addr, w_addr,
    output in_data, w_data, bias_in,
    input  neuron_rst, neuron_en, data_out, weight_out,
    output sum_in,
    input  act_out
  );

endinterface

// File: rtl/layer_sequencer.sv
// Sequences one fully connected layer: clears the perceptron bank, streams
// NUM_INPUTS input/weight pairs into it, then adds bias, applies ReLU and
// saturates each lane's sum back to the (3,5) activation format.
module layer_sequencer #(
  parameter int NUM_INPUTS   = 42,
  parameter int NUM_NEURONS  = 7,
  parameter int INPUT_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = INPUT_WIDTH + WEIGHT_WIDTH - 5,
  parameter int ADDR_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    ACT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);
  // Largest positive activation, held at the sum+1 width for the compare.
  localparam logic [SUM_WIDTH:0]    ACT_MAX  = (SUM_WIDTH + 1)'((1 << (INPUT_WIDTH - 1)) - 1);

  state_t                              state_reg, state_next;
  logic [ADDR_WIDTH-1:0]               idx_reg;
  logic                                en_reg;
  logic [NUM_NEURONS*INPUT_WIDTH-1:0]  act_reg;
  logic [NUM_NEURONS*INPUT_WIDTH-1:0]  act_next;

  // State register; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; start is only looked at in IDLE, so it never chains.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CLEAR;
      CLEAR:   state_next = ISSUE;
      ISSUE:   if (idx_reg == LAST_IDX) state_next = DRAIN;
      DRAIN:   state_next = ACT;
      ACT:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Index counter and enable: enable trails the issue slot by the memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
      en_reg  <= 1'b0;
    end else begin
      en_reg <= (state_reg == ISSUE);
      if (state_reg == CLEAR)
        idx_reg <= '0;
      else if (state_reg == ISSUE && idx_reg != LAST_IDX)
        idx_reg <= idx_reg + 1'b1;
    end
  end

  // Per lane: bias add at SUM_WIDTH+1 bits (shared (x,5) alignment), ReLU, clamp.
  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_lane
      logic signed [SUM_WIDTH-1:0]    sum_lane;
      logic signed [WEIGHT_WIDTH-1:0] bias_lane;
      logic signed [SUM_WIDTH:0]      t_lane;

      assign sum_lane  = bus.sum_in[gi*SUM_WIDTH +: SUM_WIDTH];
      assign bias_lane = bus.bias_in[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign t_lane    = (SUM_WIDTH + 1)'(sum_lane) + (SUM_WIDTH + 1)'(bias_lane);

      assign act_next[gi*INPUT_WIDTH +: INPUT_WIDTH] =
        t_lane[SUM_WIDTH]                 ? '0 :
        (unsigned'(t_lane) > ACT_MAX)     ? ACT_MAX[INPUT_WIDTH-1:0] :
                                            t_lane[INPUT_WIDTH-1:0];
    end
  endgenerate

  // Activation register: loaded only in ACT, otherwise holds the last layer result.
  always_ff @(posedge clk) begin
    if (rst)                    act_reg <= '0;
    else if (state_reg == ACT)  act_reg <= act_next;
  end

  // Output decode; data and weights pass straight through, gated by the enable.
  always_comb begin
    bus.busy       = (state_reg != IDLE);
    bus.done       = (state_reg == DONE);
    bus.neuron_rst = rst | (state_reg == CLEAR);
    bus.neuron_en  = en_reg;
    bus.in_addr    = idx_reg;
    bus.w_addr     = idx_reg;
    bus.data_out   = en_reg ? bus.in_data : '0;
    bus.weight_out = en_reg ? bus.w_data  : '0;
    bus.act_out    = act_reg;
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench: memories and a perceptron bank are modelled around the
// sequencer; expected activations are computed directly from the memory
// contents with plain arithmetic.
module tb_layer_sequencer;

  localparam int N  = 42;
  localparam int NN = 7;
  localparam int IW = 8;
  localparam int WW = 8;
  localparam int SW = IW + WW - 5;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_sequencer_if #(.NUM_INPUTS(N), .NUM_NEURONS(NN), .INPUT_WIDTH(IW),
                       .WEIGHT_WIDTH(WW)) bus ();

  layer_sequencer #(.NUM_INPUTS(N), .NUM_NEURONS(NN), .INPUT_WIDTH(IW),
                    .WEIGHT_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] in_mem [N];
  logic [7:0] w_mem  [NN][N];
  logic [7:0] bias   [NN];
  int         psum   [NN];

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat_sum(input int v);
    if (v > 1023)  return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  // Expected lane activation: saturating dot product, plus bias, ReLU, clamp 127.
  function automatic int ref_act(input int k);
    int s = 0;
    int t;
    for (int i = 0; i < N; i++)
      s = sat_sum(s + ((sx8(in_mem[i]) * sx8(w_mem[k][i])) >>> 5));
    t = s + sx8(bias[k]);
    if (t < 0)   return 0;
    if (t > 127) return 127;
    return t;
  endfunction

  // Synchronous memories with 1-cycle read latency.
  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    for (int k = 0; k < NN; k++)
      bus.w_data[k*WW +: WW] <= w_mem[k][bus.w_addr];
  end

  // Perceptron bank: saturating (x,5) accumulator per lane.
  always @(posedge clk) begin
    for (int k = 0; k < NN; k++) begin
      if (bus.neuron_rst)
        psum[k] <= 0;
      else if (bus.neuron_en)
        psum[k] <= sat_sum(psum[k] +
                   ((int'($signed(bus.data_out)) * int'($signed(bus.weight_out[k*WW +: WW]))) >>> 5));
    end
  end

  always_comb begin
    for (int k = 0; k < NN; k++) begin
      bus.sum_in[k*SW +: SW]  = psum[k][SW-1:0];
      bus.bias_in[k*WW +: WW] = bias[k];
    end
  end

  task automatic fill_uniform(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      in_mem[i] = x;
      for (int k = 0; k < NN; k++) w_mem[k][i] = w;
    end
    for (int k = 0; k < NN; k++) bias[k] = b;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      in_mem[i] = 8'($urandom);
      for (int k = 0; k < NN; k++) w_mem[k][i] = 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 15));
    end
    for (int k = 0; k < NN; k++) bias[k] = 8'($urandom);
  endtask

  task automatic check_lanes(input string tag);
    for (int k = 0; k < NN; k++) begin
      int exp_v;
      exp_v = ref_act(k);
      vectors++;
      if (bus.act_out[k*IW +: IW] !== 8'(exp_v)) begin
        miscompares++;
        $display("FAIL %s act_out[%0d]: got %0d expected %0d", tag, k, bus.act_out[k*IW +: IW], exp_v);
      end
    end
  endtask

  // One full pass from an idle sequencer; call 1 time unit after a rising edge.
  task automatic run_pass(input string tag);
    int  c = 0;
    int  en_cnt = 0;
    int  done_cyc = -1;
    bit  addr_ok = 1'b1;
    bus.start = 1'b1;
    while (c < N + 20) begin
      @(posedge clk); #1; c++;
      bus.start = 1'b0;
      if (c == 1) begin
        vectors++;
        if (bus.busy !== 1'b1 || bus.neuron_rst !== 1'b1) begin
          miscompares++;
          $display("FAIL %s clear_cycle: got busy=%b neuron_rst=%b expected 1 1", tag, bus.busy, bus.neuron_rst);
        end
      end
      if (c >= 2 && c <= N + 1)
        if (int'(bus.in_addr) != c - 2 || int'(bus.w_addr) != c - 2) addr_ok = 1'b0;
      if (c == 7) begin
        vectors++;
        if (bus.in_addr !== AW'(5)) begin
          miscompares++;
          $display("FAIL %s in_addr_cycle7: got %0d expected 5", tag, bus.in_addr);
        end
      end
      if (bus.neuron_en === 1'b1) en_cnt++;
      if (bus.done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        check_lanes(tag);
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s busy_after_done: got %b expected 0", tag, bus.busy);
        end
        break;
      end
    end
    vectors++;
    if (done_cyc != N + 4) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, N + 4);
    end
    vectors++;
    if (en_cnt != N) begin
      miscompares++;
      $display("FAIL %s en_cycles: got %0d expected %0d", tag, en_cnt, N);
    end
    vectors++;
    if (!addr_ok) begin
      miscompares++;
      $display("FAIL %s addr_sequence: got out-of-order address expected 0..%0d", tag, N - 1);
    end
    $display("pass %s: done at cycle %0d, en cycles %0d, lane0 act %0d", tag, done_cyc, en_cnt, bus.act_out[IW-1:0]);
  endtask

  task automatic test_reset();
    fill_uniform(8'h00, 8'h00, 8'h00);
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.neuron_en !== 1'b0 || bus.neuron_rst !== 1'b1 ||
        bus.in_addr !== '0 || bus.w_addr !== '0 || bus.act_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b en=%b nrst=%b addr=%0d act=%h expected 0 0 0 1 0 0",
               bus.busy, bus.done, bus.neuron_en, bus.neuron_rst, bus.in_addr, bus.act_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.neuron_rst !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got nrst=%b busy=%b expected 0 0", bus.neuron_rst, bus.busy);
    end
    $display("reset: state checked");
  endtask

  task automatic test_saturate();
    fill_uniform(8'h20, 8'h20, 8'h00);
    run_pass("saturate");
  endtask

  task automatic test_relu();
    fill_uniform(8'h20, 8'h01, 8'h00);
    for (int i = 0; i < N; i++) w_mem[0][i] = 8'hE0;
    run_pass("relu");
  endtask

  task automatic test_single_index();
    fill_uniform(8'h00, 8'h00, 8'h08);
    in_mem[5] = 8'h40;
    for (int k = 0; k < NN; k++) w_mem[k][5] = 8'h10;
    run_pass("single_index");
  endtask

  task automatic test_start_ignored();
    int c = 0;
    int n_done = 0;
    int d0 = -1;
    int d1 = -1;
    fill_random();
    bus.start = 1'b1;
    while (c < 100) begin
      @(posedge clk); #1; c++;
      bus.start = (c >= 10 && c <= 47);
      if (bus.done === 1'b1) begin
        n_done++;
        if (d0 < 0) begin d0 = c; check_lanes("start_ignored"); end
        else if (d1 < 0) d1 = c;
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (n_done != 2 || d0 != N + 4 || d1 != 2 * N + 9) begin
      miscompares++;
      $display("FAIL start_ignored: got %0d dones at %0d,%0d expected 2 at %0d,%0d", n_done, d0, d1, N + 4, 2 * N + 9);
    end
    $display("start_ignored: dones %0d at %0d and %0d", n_done, d0, d1);
  endtask

  task automatic test_abort();
    int c = 0;
    int n_done = 0;
    fill_random();
    bus.start = 1'b1;
    while (c < 20) begin
      @(posedge clk); #1; c++;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.neuron_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_neuron_rst: got %b expected 1", bus.neuron_rst);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.neuron_en !== 1'b0 || bus.act_out !== '0 || bus.in_addr !== '0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b en=%b act=%h addr=%0d expected 0 0 0 0",
               bus.busy, bus.neuron_en, bus.act_out, bus.in_addr);
    end
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n_done++;
    end
    vectors++;
    if (n_done != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d dones expected 0", n_done);
    end
    $display("abort: reset mid-pass, %0d dones afterwards", n_done);
    fill_random();
    run_pass("after_abort");
  endtask

  task automatic test_back_to_back();
    fill_uniform(8'h7F, 8'h7F, 8'h7F);
    run_pass("b2b_first");
    fill_uniform(8'h01, 8'h20, 8'h00);
    in_mem[0] = 8'h20;
    run_pass("b2b_second");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_pass($sformatf("random%0d", r));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_saturate();
    test_relu();
    test_single_index();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Drives a bank of `perceptron` accumulators through one fully connected layer of the Connect4 evaluator. It streams board inputs and per-neuron weights into the bank from synchronous memories and controls each neuron's `rst` and `en`. When accumulation finishes it collects every neuron's `sum`, adds a bias, applies ReLU and saturates the result back to the 8-bit (3,5) activation format. The outputs feed the next layer or the column-select logic.

## Interface
- `NUM_INPUTS`, 42: inputs per neuron (one per board cell).
- `NUM_NEURONS`, 7: neurons in the bank, one lane each.
- `INPUT_WIDTH`, 8: activation width, signed (3,5).
- `WEIGHT_WIDTH`, 8: weight and bias width, signed (3,5).
- `SUM_WIDTH`, `INPUT_WIDTH+WEIGHT_WIDTH-5`: neuron sum width, signed (x,5); 11 by default.
- `ADDR_WIDTH`, `$clog2(NUM_INPUTS)`: input index width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin one layer pass; sampled only in IDLE.
- `busy`, out, 1: high from CLEAR through DONE inclusive.
- `done`, out, 1: one-cycle pulse; `act_out` is valid in that cycle.
- `in_addr`, out, ADDR_WIDTH: input buffer read address.
- `w_addr`, out, ADDR_WIDTH: weight ROM read address, shared by all lanes.
- `in_data`, in, INPUT_WIDTH: input buffer read data, arriving 1 cycle after the address.
- `w_data`, in, NUM_NEURONS*WEIGHT_WIDTH: packed weights, lane k at `[k*W +: W]`, 1-cycle read latency.
- `bias_in`, in, NUM_NEURONS*WEIGHT_WIDTH: packed per-lane bias in (3,5); must be stable while `busy` is high.
- `neuron_rst`, out, 1: to every perceptron `rst`.
- `neuron_en`, out, 1: to every perceptron `en`.
- `data_out`, out, INPUT_WIDTH: broadcast to every perceptron `data_in`.
- `weight_out`, out, NUM_NEURONS*WEIGHT_WIDTH: per-lane perceptron `weight`.
- `sum_in`, in, NUM_NEURONS*SUM_WIDTH: packed perceptron `sum` outputs.
- `act_out`, out, NUM_NEURONS*INPUT_WIDTH: registered, packed activations, signed (3,5).

## Operation
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, ACT, DONE.
- IDLE: moves to CLEAR when `start` is high.
- CLEAR: lasts 1 cycle with `neuron_rst`=1; the index counter is set to 0.
- ISSUE: lasts NUM_INPUTS cycles. `in_addr` and `w_addr` equal the index, which increments each cycle; the last index is NUM_INPUTS-1, after which the FSM moves to DRAIN.
- `neuron_en` is the issue-valid flag delayed by 1 cycle, so it is high exactly NUM_INPUTS cycles.
- `data_out` = `in_data` and `weight_out` = `w_data` (combinational pass-through), qualified by `neuron_en`.
- DRAIN: lasts 1 cycle and carries the final `neuron_en`.
- ACT: lasts 1 cycle. Per lane, `t = sext(sum_k) + sext(bias_k)` is computed at SUM_WIDTH+1 bits; the (x,5) alignment is shared, so no shift is needed. Result: `t<0` gives 0; `t>127` gives 127; otherwise `t[7:0]`. The result is registered into `act_out`.
- DONE: lasts 1 cycle with `done`=1, then returns to IDLE.
- `neuron_rst` = `rst` OR (state==CLEAR).
- `start` while `busy` is high is ignored. A `start` held high in the DONE cycle does not chain. A `start` high in IDLE starts a new pass.
- `act_out` holds its value until the next ACT or until reset.
- Reset values: state IDLE; `busy`, `done`, `neuron_en` at 0; `neuron_rst` at 1 while `rst` is high; addresses 0; `act_out` 0. Reset mid-pass aborts immediately, produces no `done` and also clears the neuron bank.

## Timing
- The cycle in which IDLE samples `start` is cycle 0.
- CLEAR: cycle 1.
- ISSUE: cycles 2..N+1, with address i in cycle i+2.
- `neuron_en`: cycles 3..N+2.
- ACT: cycle N+3.
- DONE: cycle N+4, with `done` and `act_out` valid. This is cycle 46 for N=42.
- Throughput: one pass per N+5 cycles.
- `sum_in` is sampled only in ACT; it is stable there because the last enable was in DRAIN.

## Test plan
- All inputs 0x20 (1.0), all weights 0x20, bias 0, N=42 -> each sum = 42.0 (1344), which saturates, so `act_out` lanes = 127; `done` in cycle 46.
- Inputs 0x20, lane 0 weights 0xE0 (-1.0), others 0x01 -> lane 0 `act_out` = 0 (ReLU). Each other lane sums 42*(1/32) to 42, so `act_out` = 42.
- Only input index 5 = 0x40 (2.0) and weight index 5 = 0x10 (0.5), bias 0x08 -> every lane `act_out` = 0x28 (1.25). Also check `in_addr` = 5 in cycle 7 and `neuron_en` high in exactly 42 cycles.
- `start` pulsed again at cycle 10 and held high through DONE -> only one `done` at 46; `start` re-asserted in IDLE at cycle 47 -> next `done` at 93.
- `rst` asserted at cycle 20 for 1 cycle -> state IDLE, `neuron_rst` high, no `done`, `act_out` 0. A fresh `start` then gives correct results.
- Back-to-back passes with different inputs -> the second result is not contaminated by the first, verifying the CLEAR pulse.
